// File: rtl/input_port_buffer_if.sv
// Link-side bundle for one router input port.
//  data_in/data_valid : flit from the upstream router's output register
//  full               : back-pressure to upstream
//  ready              : switch allocator grant / not requesting
//  data_head/label    : head flit and its XY route request
//  empty/count        : FIFO status
// master = upstream router + switch allocator, slave = input_port_buffer.
interface input_port_buffer_if #(
  parameter int unsigned DATASIZE = 40,
  parameter int unsigned WIDTH    = 3
) ();

  logic [DATASIZE-1:0] data_in;
  logic                data_valid;
  logic                full;
  logic                ready;
  logic [DATASIZE-1:0] data_head;
  logic [3:0]          label;
  logic                empty;
  logic [WIDTH:0]      count;

  modport master (
    output data_in,
    output data_valid,
    output ready,
    input  full,
    input  data_head,
    input  label,
    input  empty,
    input  count
  );

  modport slave (
    input  data_in,
    input  data_valid,
    input  ready,
    output full,
    output data_head,
    output label,
    output empty,
    output count
  );

endinterface

// File: rtl/input_port_buffer.sv
// Receive side of an inter-router link: buffers incoming flits in a FIFO,
// returns back-pressure (full) upstream and presents the head flit with its
// XY route label to the switch allocator, popping on ready.
// Ports:
//  clk   : rising-edge clock
//  rst_n : asynchronous active-low reset
//  bus   : slave side of input_port_buffer_if
//          (data_in, data_valid, ready in; full, data_head, label, empty, count out)
// full/empty/count are registers; data_head/label are decoded from the
// registered read pointer and storage, so nothing combinational runs from
// data_valid or ready to any output.
module input_port_buffer #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned WIDTH    = 3,
  parameter int unsigned DATASIZE = 40,
  parameter int unsigned X_ID     = 0,
  parameter int unsigned Y_ID     = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input_port_buffer_if.slave   bus
);

  localparam int unsigned CW = WIDTH + 1;

  localparam logic [3:0] LBL_NONE  = 4'b1111;
  localparam logic [3:0] LBL_EAST  = 4'b0010;
  localparam logic [3:0] LBL_WEST  = 4'b1000;
  localparam logic [3:0] LBL_SOUTH = 4'b0001;
  localparam logic [3:0] LBL_NORTH = 4'b0100;
  localparam logic [3:0] LBL_LOCAL = 4'b0000;

  // Flit storage (not reset)
  logic [DATASIZE-1:0] mem [DEPTH];

  logic [WIDTH-1:0] wr_ptr, wr_ptr_nxt;
  logic [WIDTH-1:0] rd_ptr, rd_ptr_nxt;
  logic [CW-1:0]    count_q, count_nxt;
  logic             full_q, full_nxt;
  logic             empty_q, empty_nxt;

  logic             push_c;
  logic             pop_c;
  logic [DATASIZE-1:0] head_c;
  logic [1:0]       dx_c, dy_c;
  logic [3:0]       label_c;

  // Next-state: qualified push/pop, pointer and occupancy update
  always_comb begin
    push_c     = 1'b0;
    pop_c      = 1'b0;
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    count_nxt  = count_q;

    // Flags are registered, so a pop while full cannot make room this cycle
    push_c = bus.data_valid & ~full_q;
    pop_c  = bus.ready & ~empty_q;

    if (push_c) begin
      wr_ptr_nxt = wr_ptr + WIDTH'(1);
    end
    if (pop_c) begin
      rd_ptr_nxt = rd_ptr + WIDTH'(1);
    end

    unique case ({push_c, pop_c})
      2'b10:   count_nxt = count_q + CW'(1);
      2'b01:   count_nxt = count_q - CW'(1);
      default: count_nxt = count_q;
    endcase

    full_nxt  = (count_nxt == CW'(DEPTH));
    empty_nxt = (count_nxt == CW'(0));
  end

  // Control state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wr_ptr  <= wr_ptr_nxt;
      rd_ptr  <= rd_ptr_nxt;
      count_q <= count_nxt;
      full_q  <= full_nxt;
      empty_q <= empty_nxt;
    end
  end

  // Storage write
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr] <= bus.data_in;
    end
  end

  // Head flit and XY route decode; empty forces zero data and "no request"
  always_comb begin
    head_c  = '0;
    dx_c    = '0;
    dy_c    = '0;
    label_c = LBL_NONE;

    if (!empty_q) begin
      head_c = mem[rd_ptr];
    end
    dx_c = head_c[35:34];
    dy_c = head_c[33:32];

    if (empty_q) begin
      label_c = LBL_NONE;
    end else if (dx_c > 2'(X_ID)) begin
      label_c = LBL_EAST;
    end else if (dx_c < 2'(X_ID)) begin
      label_c = LBL_WEST;
    end else if (dy_c > 2'(Y_ID)) begin
      label_c = LBL_SOUTH;
    end else if (dy_c < 2'(Y_ID)) begin
      label_c = LBL_NORTH;
    end else begin
      label_c = LBL_LOCAL;
    end
  end

  assign bus.full      = full_q;
  assign bus.empty     = empty_q;
  assign bus.count     = count_q;
  assign bus.data_head = head_c;
  assign bus.label     = label_c;

endmodule

// File: tb/tb_input_port_buffer.sv
// Bench for input_port_buffer (X_ID=1, Y_ID=1): a queue model of the FIFO is
// compared against every output on each falling edge, plus directed literal
// checks and a randomized traffic phase.
module tb_input_port_buffer;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned XI    = 1;
  localparam int unsigned YI    = 1;

  logic clk;
  logic rst_n;

  input_port_buffer_if #(.DATASIZE(40), .WIDTH(3)) bus ();

  input_port_buffer #(
    .DEPTH(8), .WIDTH(3), .DATASIZE(40), .X_ID(XI), .Y_ID(YI)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit checking = 1'b0;

  logic [39:0] mq [$];

  function automatic logic [3:0] exp_label(input logic [39:0] f, input bit emp);
    int dx, dy;
    dx = int'(f[35:34]);
    dy = int'(f[33:32]);
    if (emp)            return 4'b1111;
    if (dx > int'(XI))  return 4'b0010;
    if (dx < int'(XI))  return 4'b1000;
    if (dy > int'(YI))  return 4'b0001;
    if (dy < int'(YI))  return 4'b0100;
    return 4'b0000;
  endfunction

  function automatic logic [39:0] make_flit();
    return {8'($urandom), 32'($urandom)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: queue semantics with registered-flag qualification
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
    end else begin
      bit pu, po;
      pu = bus.data_valid && (mq.size() < DEPTH);
      po = bus.ready && (mq.size() > 0);
      if (po) void'(mq.pop_front());
      if (pu) mq.push_back(bus.data_in);
    end
  end

  // Cycle compare against the model
  always @(negedge clk) begin
    if (checking) begin
      bit emp;
      logic [39:0] h;
      emp = (mq.size() == 0);
      h   = emp ? 40'h0 : mq[0];
      chk("m_count", 64'(bus.count), 64'(mq.size()));
      chk("m_empty", 64'(bus.empty), 64'(emp));
      chk("m_full",  64'(bus.full),  64'(mq.size() == DEPTH));
      chk("m_head",  64'(bus.data_head), 64'(h));
      chk("m_label", 64'(bus.label), 64'(exp_label(h, emp)));
    end
  end

  logic [3:0]  dsts [5] = '{4'b1101, 4'b0001, 4'b0110, 4'b0100, 4'b0101};
  logic [3:0]  lbls [5] = '{4'b0010, 4'b1000, 4'b0001, 4'b0100, 4'b0000};

  initial begin
    logic [39:0] f;
    bit acc;
    int rp;

    rst_n          = 1'b0;
    bus.data_in    = '0;
    bus.data_valid = 1'b0;
    bus.ready      = 1'b0;
    step();
    checking = 1'b1;
    step();

    // 1) reset values
    chk("rst_empty", 64'(bus.empty), 64'd1);
    chk("rst_full",  64'(bus.full),  64'd0);
    chk("rst_count", 64'(bus.count), 64'd0);
    chk("rst_label", 64'(bus.label), 64'hF);
    chk("rst_head",  64'(bus.data_head), 64'd0);
    rst_n = 1'b1;
    step();
    chk("idle_label", 64'(bus.label), 64'hF);

    // 2) route label per destination
    for (int i = 0; i < 5; i++) begin
      f = {4'h3, dsts[i], 32'($urandom)};
      bus.data_in    = f;
      bus.data_valid = 1'b1;
      step();
      bus.data_valid = 1'b0;
      chk("lbl_count", 64'(bus.count), 64'd1);
      chk("lbl_label", 64'(bus.label), 64'(lbls[i]));
      chk("lbl_head",  64'(bus.data_head), 64'(f));
      bus.ready = 1'b1;
      step();
      bus.ready = 1'b0;
      chk("lbl_drain", 64'(bus.empty), 64'd1);
    end

    // 3) fill, blocked offer, pop-while-full
    for (int i = 0; i < 8; i++) begin
      bus.data_in    = make_flit();
      bus.data_valid = 1'b1;
      step();
    end
    bus.data_in = 40'hAA;
    chk("fill_full",  64'(bus.full),  64'd1);
    chk("fill_count", 64'(bus.count), 64'd8);
    repeat (3) step();
    chk("blk_count", 64'(bus.count), 64'd8);
    bus.ready = 1'b1;
    step();
    bus.ready = 1'b0;
    chk("popfull_count", 64'(bus.count), 64'd7);
    chk("popfull_full",  64'(bus.full),  64'd0);
    step();
    bus.data_valid = 1'b0;
    chk("aa_count", 64'(bus.count), 64'd8);
    chk("aa_full",  64'(bus.full),  64'd1);
    bus.ready = 1'b1;
    repeat (7) step();
    chk("aa_head",  64'(bus.data_head), 64'hAA);
    chk("aa_last",  64'(bus.count), 64'd1);
    step();
    chk("aa_empty", 64'(bus.empty), 64'd1);
    bus.ready = 1'b0;

    // 4) streaming push+pop
    bus.ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      f = make_flit();
      bus.data_in    = f;
      bus.data_valid = 1'b1;
      step();
      chk("str_count", 64'(bus.count), 64'd1);
      chk("str_head",  64'(bus.data_head), 64'(f));
    end
    bus.data_valid = 1'b0;
    step();
    chk("str_empty", 64'(bus.empty), 64'd1);

    // 5) ready on empty FIFO must not move the read pointer
    repeat (5) step();
    chk("e_count", 64'(bus.count), 64'd0);
    bus.ready = 1'b0;
    f = make_flit();
    bus.data_in    = f;
    bus.data_valid = 1'b1;
    step();
    bus.data_valid = 1'b0;
    chk("e_head", 64'(bus.data_head), 64'(f));
    bus.ready = 1'b1;
    step();
    bus.ready = 1'b0;

    // 6) asynchronous reset with queued flits
    for (int i = 0; i < 5; i++) begin
      bus.data_in    = make_flit();
      bus.data_valid = 1'b1;
      step();
    end
    bus.data_valid = 1'b0;
    chk("pre_rst_count", 64'(bus.count), 64'd5);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_count", 64'(bus.count), 64'd0);
    chk("arst_label", 64'(bus.label), 64'hF);
    chk("arst_empty", 64'(bus.empty), 64'd1);
    chk("arst_head",  64'(bus.data_head), 64'd0);
    step();
    rst_n = 1'b1;
    f = make_flit();
    bus.data_in    = f;
    bus.data_valid = 1'b1;
    step();
    bus.data_valid = 1'b0;
    chk("post_rst_head",  64'(bus.data_head), 64'(f));
    chk("post_rst_count", 64'(bus.count), 64'd1);

    // Randomized traffic; upstream holds its flit until accepted
    for (int i = 0; i < 600; i++) begin
      case (i / 150)
        0:       rp = 20;
        1:       rp = 85;
        2:       rp = 50;
        default: rp = 97;
      endcase
      acc = bus.data_valid && (mq.size() < DEPTH);
      bus.ready = ($urandom_range(0, 99) < rp);
      if (!bus.data_valid || acc) begin
        bus.data_valid = ($urandom_range(0, 3) != 0);
        bus.data_in    = make_flit();
      end
      step();
    end
    bus.data_valid = 1'b0;
    bus.ready      = 1'b1;
    repeat (10) step();
    chk("final_empty", 64'(bus.empty), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
